// File: rtl/mem_pattern_apb_master.sv
// APB3 master that writes a base/checkerboard pattern into every word of an SRAM slave,
// reads it back and reports mismatches and PREADY timeouts to the test controller.
module mem_pattern_apb_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int TIMEOUT      = 15,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    start,
  input  logic                    verify_only,
  input  logic [DATA_WIDTH-1:0]   pattern,
  input  logic                    checkerboard,
  output logic                    busy,
  output logic                    done,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-3:0]   first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_data,
  output logic                    timeout_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]        LAST_IDX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0]        ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX  = {ERRCNT_WIDTH{1'b1}};
  localparam logic [ERRCNT_WIDTH-1:0] ERR_ZERO = {ERRCNT_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Expected word value: odd words are inverted when checkerboard is enabled.
  function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [DATA_WIDTH-1:0] pat,
                                                   input logic                  cb,
                                                   input logic [IDX_W-1:0]      idx);
    return pat ^ {DATA_WIDTH{cb & idx[0]}};
  endfunction

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic                    phase_rd_r, phase_rd_s;
  logic [DATA_WIDTH-1:0]   pat_r, pat_s;
  logic                    cb_r, cb_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [ERRCNT_WIDTH-1:0] err_r, err_s;
  logic [IDX_W-1:0]        fea_r, fea_s;
  logic [DATA_WIDTH-1:0]   fed_r, fed_s;
  logic                    to_r, to_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    psel_r, psel_s;
  logic                    penable_r, penable_s;
  logic                    pwrite_r, pwrite_s;
  logic [ADDR_WIDTH-1:0]   paddr_r, paddr_s;
  logic [DATA_WIDTH-1:0]   pwdata_r, pwdata_s;
  logic [DATA_WIDTH-1:0]   exp_cur_s;
  logic                    mismatch_s;

  assign exp_cur_s  = exp_of(pat_r, cb_r, idx_r);
  assign mismatch_s = phase_rd_r & ((PRDATA != exp_cur_s) | PSLVERR);

  // Next-state, datapath and registered-output computation for the run FSM.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    phase_rd_s = phase_rd_r;
    pat_s      = pat_r;
    cb_s       = cb_r;
    cnt_s      = cnt_r;
    err_s      = err_r;
    fea_s      = fea_r;
    fed_s      = fed_r;
    to_s       = to_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    psel_s     = psel_r;
    penable_s  = penable_r;
    pwrite_s   = pwrite_r;
    paddr_s    = paddr_r;
    pwdata_s   = pwdata_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pat_s      = pattern;
          cb_s       = checkerboard;
          phase_rd_s = verify_only;
          idx_s      = ZERO_IDX;
          cnt_s      = {CNT_W{1'b0}};
          err_s      = ERR_ZERO;
          fea_s      = ZERO_IDX;
          fed_s      = {DATA_WIDTH{1'b0}};
          to_s       = 1'b0;
          busy_s     = 1'b1;
          psel_s     = 1'b1;
          penable_s  = 1'b0;
          pwrite_s   = ~verify_only;
          paddr_s    = {ZERO_IDX, 2'b00};
          pwdata_s   = pattern;
          state_s    = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETUP: begin
        cnt_s     = {CNT_W{1'b0}};
        penable_s = 1'b1;
        state_s   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          psel_s    = 1'b0;
          penable_s = 1'b0;
          state_s   = ST_GAP;
          if (mismatch_s) begin
            // The first mismatch of a run is the only one that captures address/data.
            if (err_r == ERR_ZERO) begin
              fea_s = idx_r;
              fed_s = PRDATA;
            end else begin
              fea_s = fea_r;
              fed_s = fed_r;
            end
            if (err_r != ERR_MAX) begin
              err_s = err_r + ERRCNT_WIDTH'(1);
            end else begin
              err_s = err_r;
            end
          end else begin
            err_s = err_r;
          end
        end else if (cnt_r == CNT_LAST) begin
          psel_s    = 1'b0;
          penable_s = 1'b0;
          to_s      = 1'b1;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          state_s   = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (idx_r != LAST_IDX) begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = ST_SETUP;
        end else if (!phase_rd_r) begin
          idx_s      = ZERO_IDX;
          phase_rd_s = 1'b1;
          state_s    = ST_SETUP;
        end else begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end
        if (state_s == ST_SETUP) begin
          psel_s    = 1'b1;
          penable_s = 1'b0;
          pwrite_s  = ~phase_rd_s;
          paddr_s   = {idx_s, 2'b00};
          pwdata_s  = exp_of(pat_r, cb_r, idx_s);
        end else begin
          psel_s    = 1'b0;
          penable_s = 1'b0;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        busy_s    = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus and clears all results at once.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= ST_IDLE;
      idx_r      <= ZERO_IDX;
      phase_rd_r <= 1'b0;
      pat_r      <= {DATA_WIDTH{1'b0}};
      cb_r       <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      err_r      <= ERR_ZERO;
      fea_r      <= ZERO_IDX;
      fed_r      <= {DATA_WIDTH{1'b0}};
      to_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      psel_r     <= 1'b0;
      penable_r  <= 1'b0;
      pwrite_r   <= 1'b0;
      paddr_r    <= {ADDR_WIDTH{1'b0}};
      pwdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      phase_rd_r <= phase_rd_s;
      pat_r      <= pat_s;
      cb_r       <= cb_s;
      cnt_r      <= cnt_s;
      err_r      <= err_s;
      fea_r      <= fea_s;
      fed_r      <= fed_s;
      to_r       <= to_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      psel_r     <= psel_s;
      penable_r  <= penable_s;
      pwrite_r   <= pwrite_s;
      paddr_r    <= paddr_s;
      pwdata_r   <= pwdata_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign err_count      = err_r;
  assign first_err_addr = fea_r;
  assign first_err_data = fed_r;
  assign timeout_err    = to_r;
  assign PSEL           = psel_r;
  assign PENABLE        = penable_r;
  assign PWRITE         = pwrite_r;
  assign PADDR          = paddr_r;
  assign PWDATA         = pwdata_r;

endmodule

// File: tb/tb_mem_pattern_apb_master.sv
// Directed bench: SRAM-wrapper slave model, bus monitor, table of full runs plus
// hand-written reset, timeout and start-while-busy/saturation sequences.
module tb_mem_pattern_apb_master;

  localparam int DEPTH = 64;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       start = 1'b0, verify_only = 1'b0, checkerboard = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       busy, done, timeout_err;
  logic [15:0] err_count;
  logic [5:0] first_err_addr;
  logic [7:0] first_err_data;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] PADDR, PWDATA, PRDATA;

  logic       start2 = 1'b0, verify_only2 = 1'b0;
  logic [7:0] pattern2 = 8'h00;
  logic       busy2, done2, timeout_err2;
  logic [3:0] err_count2;
  logic [5:0] first_err_addr2;
  logic [7:0] first_err_data2;
  logic       PSEL2, PENABLE2, PWRITE2, PREADY2;
  logic [7:0] PADDR2, PWDATA2;

  always #5 PCLK = ~PCLK;

  mem_pattern_apb_master dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .verify_only(verify_only),
    .pattern(pattern), .checkerboard(checkerboard), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .timeout_err(timeout_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  mem_pattern_apb_master #(.ERRCNT_WIDTH(4)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .start(start2), .verify_only(verify_only2),
    .pattern(pattern2), .checkerboard(1'b0), .busy(busy2), .done(done2),
    .err_count(err_count2), .first_err_addr(first_err_addr2), .first_err_data(first_err_data2),
    .timeout_err(timeout_err2), .PSEL(PSEL2), .PENABLE(PENABLE2), .PWRITE(PWRITE2),
    .PADDR(PADDR2), .PWDATA(PWDATA2), .PRDATA(8'h00), .PREADY(PREADY2), .PSLVERR(1'b0)
  );

  // SRAM-wrapper model: zero-wait writes, 3-wait reads, optional stuck bit and hung read.
  logic [7:0] mem [DEPTH];
  logic [3:0] wait_cnt;
  logic       stuck_en = 1'b0, hang_en = 1'b0;
  logic [5:0] bus_idx;
  assign bus_idx = PADDR[7:2];
  assign PREADY  = PSEL && PENABLE && !(hang_en && !PWRITE && bus_idx == 6'd3)
                   && (wait_cnt >= (PWRITE ? 4'd0 : 4'd3));
  assign PRDATA  = mem[bus_idx];
  assign PSLVERR = 1'b0;
  assign PREADY2 = PSEL2 && PENABLE2;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wait_cnt <= 4'd0;
    else if (PSEL && PENABLE) begin
      if (PREADY) begin
        wait_cnt <= 4'd0;
        if (PWRITE) mem[bus_idx] <= (stuck_en && bus_idx == 6'd5) ? (PWDATA & 8'hFE) : PWDATA;
      end else wait_cnt <= wait_cnt + 4'd1;
    end else wait_cnt <= 4'd0;
  end

  // Bus monitor sampled on the falling edge; counters restart when a run is requested.
  int n_starts, n_wr, n_rd, n_done, n_busy, max_acc, acc_len, gap_len, n_viol;
  int n_wr2, n_rd2, n_done2;
  logic first_xfer, prev_setup, hold_write;
  logic [7:0] hold_addr, hold_data, cur_pat;
  logic cur_cb;

  always @(negedge PCLK) begin
    if (start && !busy && !done) begin
      n_starts = 0; n_wr = 0; n_rd = 0; n_done = 0; n_busy = 0; max_acc = 0;
      acc_len = 0; gap_len = 0; n_viol = 0; first_xfer = 1'b1;
      cur_pat = pattern; cur_cb = checkerboard;
    end
    if (busy) n_busy++;
    if (done) n_done++;
    if (PSEL && !PENABLE) begin
      n_starts++;
      if (!first_xfer && gap_len != 1) n_viol++;
      first_xfer = 1'b0;
      gap_len = 0;
      if (PWDATA !== (cur_pat ^ ((cur_cb && PADDR[2]) ? 8'hFF : 8'h00))) n_viol++;
      hold_addr = PADDR; hold_data = PWDATA; hold_write = PWRITE;
    end else if (PSEL && PENABLE) begin
      if (acc_len == 0 && !prev_setup) n_viol++;
      acc_len++;
      if (acc_len > max_acc) max_acc = acc_len;
      if (PADDR !== hold_addr || PWDATA !== hold_data || PWRITE !== hold_write) n_viol++;
      if (PREADY) begin
        if (PWRITE) n_wr++; else n_rd++;
        acc_len = 0;
      end
    end else begin
      if (PENABLE) n_viol++;
      gap_len++;
      acc_len = 0;
    end
    prev_setup = PSEL && !PENABLE;

    if (start2 && !busy2 && !done2) begin n_wr2 = 0; n_rd2 = 0; n_done2 = 0; end
    if (done2) n_done2++;
    if (PSEL2 && PENABLE2 && PREADY2) begin
      if (PWRITE2) n_wr2++; else n_rd2++;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vo;
    logic [7:0] pat;
    logic       cb;
    logic       stuck;
    logic       hang;
    int         e_err;
    int         e_fa;
    int         e_fd;
    logic       e_to;
    int         e_wr;
    int         e_rd;
    int         e_starts;
    int         e_cyc;
    int         e_maxacc;
  } vec_t;

  vec_t tbl [5];

  task automatic pulse_start();
    @(posedge PCLK); #2 start = 1'b1;
    @(posedge PCLK); #2 start = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    logic got;
    stuck_en = v.stuck; hang_en = v.hang;
    verify_only = v.vo; pattern = v.pat; checkerboard = v.cb;
    pulse_start();
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge PCLK);
      if (done) got = 1'b1;
    end
    check($sformatf("%s done_seen", tag), got, 1);
    repeat (3) @(negedge PCLK);
    check($sformatf("%s err_count", tag), err_count, v.e_err);
    check($sformatf("%s first_err_addr", tag), first_err_addr, v.e_fa);
    check($sformatf("%s first_err_data", tag), first_err_data, v.e_fd);
    check($sformatf("%s timeout_err", tag), timeout_err, v.e_to);
    check($sformatf("%s writes", tag), n_wr, v.e_wr);
    check($sformatf("%s reads", tag), n_rd, v.e_rd);
    check($sformatf("%s setups", tag), n_starts, v.e_starts);
    check($sformatf("%s busy_cycles", tag), n_busy, v.e_cyc);
    check($sformatf("%s max_access", tag), max_acc, v.e_maxacc);
    check($sformatf("%s done_pulses", tag), n_done, 1);
    check($sformatf("%s protocol", tag), n_viol, 0);
    check($sformatf("%s busy_after", tag), busy, 0);
  endtask

  initial begin
    logic got;
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0,  0, 0,     1'b0, 64, 64, 128, 576, 4};
    tbl[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1,  5, 8'hFE, 1'b0, 64, 64, 128, 576, 4};
    tbl[2] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 0,  0, 0,     1'b0, 64, 64, 128, 576, 4};
    tbl[3] = '{1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 0,  0, 0,     1'b1, 64, 3,  68,  226, 15};
    tbl[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 64, 0, 8'h12, 1'b0, 0,  64, 64,  384, 4};

    repeat (3) @(negedge PCLK);
    check("rst PSEL", PSEL, 0);
    check("rst PENABLE", PENABLE, 0);
    check("rst PADDR", PADDR, 0);
    check("rst busy", busy, 0);
    check("rst err_count", err_count, 0);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    check("idle done", done, 0);
    check("idle PWDATA", PWDATA, 0);

    for (int r = 0; r < 5; r++) run_row(tbl[r], $sformatf("row%0d", r));

    // Async reset clears held results while idle.
    #1 PRESET = 1'b1; #1;
    check("idle_rst err_count", err_count, 0);
    check("idle_rst first_err_data", first_err_data, 0);
    @(negedge PCLK); PRESET = 1'b0;

    // Reset during the ACCESS phase of the write to word 10.
    verify_only = 1'b0; pattern = 8'h33; checkerboard = 1'b0;
    pulse_start();
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PWRITE && PADDR == 8'd40) got = 1'b1;
    end
    check("mid_rst reached_w10", got, 1);
    #1 PRESET = 1'b1; #1;
    check("mid_rst PSEL", PSEL, 0);
    check("mid_rst PENABLE", PENABLE, 0);
    check("mid_rst busy", busy, 0);
    check("mid_rst PADDR", PADDR, 0);
    check("mid_rst PWDATA", PWDATA, 0);
    check("mid_rst err_count", err_count, 0);
    check("mid_rst timeout_err", timeout_err, 0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    run_row('{1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 64, 64, 128, 576, 4}, "post_rst");

    // Narrow counter saturates; a second start mid-run must be ignored.
    verify_only2 = 1'b0; pattern2 = 8'h3C;
    @(posedge PCLK); #2 start2 = 1'b1;
    @(posedge PCLK); #2 start2 = 1'b0;
    repeat (60) @(posedge PCLK);
    #2 start2 = 1'b1; verify_only2 = 1'b1; pattern2 = 8'hC3;
    @(posedge PCLK); #2 start2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge PCLK);
      if (done2) got = 1'b1;
    end
    check("sat done_seen", got, 1);
    repeat (3) @(negedge PCLK);
    check("sat err_count", err_count2, 15);
    check("sat first_err_addr", first_err_addr2, 0);
    check("sat first_err_data", first_err_data2, 0);
    check("sat writes", n_wr2, 64);
    check("sat reads", n_rd2, 64);
    check("sat done_pulses", n_done2, 1);
    check("sat timeout_err", timeout_err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
